wishbone_arbiter: RTL and testbench
===================================

WISHBONE_ARBITER -- requirements
Module: wishbone_arbiter

Interface
Parameters:
REQ-001 N_MASTERS, 2, number of requesting Wishbone masters (legal 2..8).
REQ-002 TIMEOUT, 16, max cycles an unanswered strobe may wait (legal 2..255).
Ports:
REQ-003 clk_i  in  1  single clock; all state updates on rising edge.
REQ-004 rstn_i  in  1  reset, asynchronous and active-low.
REQ-005 m_cyc_i, m_stb_i, m_we_i  in  N_MASTERS each  per-master cycle, strobe and write enable.
REQ-006 m_adr_i, m_dat_i  in  32*N_MASTERS each  per-master address and write data; master k uses bits [32k+31:32k].
REQ-007 m_sel_i  in  4*N_MASTERS  per-master byte select; master k uses bits [4k+3:4k].
REQ-008 m_dat_o  out  32  read data broadcast to all masters.
REQ-009 m_ack_o, m_err_o, m_rty_o  out  N_MASTERS each  per-master termination.
REQ-010 s_cyc_o, s_stb_o, s_we_o  out  1 each  shared-slave cycle, strobe and write enable.
REQ-011 s_adr_o, s_dat_o  out  32 each; s_sel_o  out  4  granted master's address, data and select.
REQ-012 s_dat_i  in  32; s_ack_i, s_err_i, s_rty_i  in  1 each  slave read data and terminations.
REQ-013 grant_o  out  N_MASTERS  one-hot current owner, all-zero when idle.

Function
REQ-014 Two states: IDLE (no owner) and BUSY (one owner).
REQ-015 IDLE -> BUSY on the edge where any m_cyc_i bit is 1; the owner is the first requester found by searching upward from (last_owner+1) mod N_MASTERS, wrapping around.
REQ-016 Grant latency is exactly one cycle: a request sampled in IDLE makes grant_o valid the next cycle.
REQ-017 last_owner updates only when a grant is taken; it is unaffected by reset-free idling.
REQ-018 In BUSY, s_cyc_o = owner's m_cyc_i, s_stb_o = owner's m_stb_i, and s_we_o/s_adr_o/s_dat_o/s_sel_o are combinationally muxed from the owner.
REQ-019 In IDLE all s_* outputs are 0.
REQ-020 m_ack_o/m_err_o/m_rty_o drive only the owner's bit, copied combinationally from s_ack_i/s_err_i/s_rty_i; non-owners see 0. m_dat_o = s_dat_i always.
REQ-021 Ownership is held for the whole cycle (multiple strobes/bursts); BUSY -> IDLE on the edge where the owner's m_cyc_i is 0; at least one IDLE cycle separates consecutive grants.
REQ-022 Requests from non-owners are ignored, not queued; they are re-evaluated in IDLE.
REQ-023 An 8-bit wait counter clears in IDLE and on any cycle with s_ack_i|s_err_i|s_rty_i, and increments each BUSY cycle with s_stb_o=1 and no termination.
REQ-024 When the counter equals TIMEOUT-1 with no slave termination, the owner's m_err_o is forced to 1 for that cycle and the counter clears; the slave is not terminated and ownership is not revoked.
REQ-025 Simultaneous slave termination and timeout: slave termination wins, no forced error.
REQ-026 Slave terminations arriving in IDLE are discarded.

Reset
REQ-027 While rstn_i=0: state=IDLE, grant_o=0, counter=0, last_owner=N_MASTERS-1 (so master 0 wins first arbitration), all s_* and m_ack/err/rty outputs 0.
REQ-028 Reset assertion mid-cycle aborts the transfer immediately; no termination is delivered to the former owner.
REQ-029 After reset release, first arbitration occurs on the first rising edge with any m_cyc_i=1.

Verification
REQ-030 N=2; master0 write adr 0x10, data 0xDEADBEEF, sel 0xF, slave acks same cycle -> grant_o=01 one cycle after request, s_adr_o=0x10, m_ack_o=01 in ack cycle.
REQ-031 Both masters request continuously, each single-beat cycles -> grants alternate 01,10,01,10 with one IDLE cycle between.
REQ-032 Master1 owns; master0 raises cyc mid-cycle -> master0 sees no ack/data until master1 drops cyc, then grant_o=01.
REQ-033 TIMEOUT=4, slave never responds -> owner's m_err_o=1 on the 4th strobe cycle, counter restarts, grant unchanged.
REQ-034 4-beat burst by master0, ack every cycle -> four m_ack_o pulses on bit 0, grant held throughout.
REQ-035 rstn_i low during BUSY -> same cycle grant_o=0, s_cyc_o=0; next arbitration picks master0.

Source files
------------

// File: rtl/wishbone_arbiter.sv
// Round-robin arbiter granting one of N_MASTERS Wishbone masters access to a shared slave,
// with a per-strobe wait timeout that injects an error to the owner.
module wishbone_arbiter #(
    parameter int unsigned N_MASTERS = 2,
    parameter int unsigned TIMEOUT   = 16
) (
    input  logic                    clk_i,
    input  logic                    rstn_i,
    input  logic [N_MASTERS-1:0]    m_cyc_i,
    input  logic [N_MASTERS-1:0]    m_stb_i,
    input  logic [N_MASTERS-1:0]    m_we_i,
    input  logic [32*N_MASTERS-1:0] m_adr_i,
    input  logic [32*N_MASTERS-1:0] m_dat_i,
    input  logic [4*N_MASTERS-1:0]  m_sel_i,
    output logic [31:0]             m_dat_o,
    output logic [N_MASTERS-1:0]    m_ack_o,
    output logic [N_MASTERS-1:0]    m_err_o,
    output logic [N_MASTERS-1:0]    m_rty_o,
    output logic                    s_cyc_o,
    output logic                    s_stb_o,
    output logic                    s_we_o,
    output logic [31:0]             s_adr_o,
    output logic [31:0]             s_dat_o,
    output logic [3:0]              s_sel_o,
    input  logic [31:0]             s_dat_i,
    input  logic                    s_ack_i,
    input  logic                    s_err_i,
    input  logic                    s_rty_i,
    output logic [N_MASTERS-1:0]    grant_o
);

    localparam int unsigned IW    = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
    localparam logic [7:0]  LIMIT = 8'(TIMEOUT - 1);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t          state, state_nx;
    logic [IW-1:0]   owner, owner_nx;
    logic [IW-1:0]   last, last_nx;
    logic [IW-1:0]   pick, cand;
    logic            hit;
    logic [7:0]      cnt, cnt_nx;
    logic            busy, term, timeout;

    assign busy    = (state == BUSY);
    assign term    = s_ack_i | s_err_i | s_rty_i;
    assign timeout = busy && s_stb_o && !term && (cnt == LIMIT);
    assign m_dat_o = s_dat_i;

    // Search upward from the slot after the previous owner, wrapping around.
    always_comb begin
        pick = '0;
        cand = '0;
        hit  = 1'b0;
        for (int unsigned i = 1; i <= N_MASTERS; i++) begin
            cand = IW'((32'(last) + i) % N_MASTERS);
            if (!hit && m_cyc_i[cand]) begin
                pick = cand;
                hit  = 1'b1;
            end
        end
    end

    always_comb begin
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        s_we_o  = 1'b0;
        s_adr_o = '0;
        s_dat_o = '0;
        s_sel_o = '0;
        grant_o = '0;
        m_ack_o = '0;
        m_err_o = '0;
        m_rty_o = '0;
        for (int unsigned k = 0; k < N_MASTERS; k++) begin
            if (busy && owner == IW'(k)) begin
                grant_o[k] = 1'b1;
                s_cyc_o    = m_cyc_i[k];
                s_stb_o    = m_stb_i[k];
                s_we_o     = m_we_i[k];
                s_adr_o    = m_adr_i[32*k +: 32];
                s_dat_o    = m_dat_i[32*k +: 32];
                s_sel_o    = m_sel_i[4*k +: 4];
            end
        end
        for (int unsigned k = 0; k < N_MASTERS; k++) begin
            m_ack_o[k] = grant_o[k] & s_ack_i;
            m_err_o[k] = grant_o[k] & (s_err_i | timeout);
            m_rty_o[k] = grant_o[k] & s_rty_i;
        end
    end

    always_comb begin
        state_nx = state;
        owner_nx = owner;
        last_nx  = last;
        cnt_nx   = cnt;
        case (state)
            IDLE: begin
                cnt_nx = '0;
                if (hit) begin
                    state_nx = BUSY;
                    owner_nx = pick;
                    last_nx  = pick;
                end
            end
            BUSY: begin
                if (term || timeout)
                    cnt_nx = '0;
                else if (s_stb_o)
                    cnt_nx = cnt + 8'd1;
                if (!s_cyc_o)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state <= IDLE;
            owner <= '0;
            last  <= IW'(N_MASTERS - 1);
            cnt   <= '0;
        end else begin
            state <= state_nx;
            owner <= owner_nx;
            last  <= last_nx;
            cnt   <= cnt_nx;
        end
    end

endmodule

// File: tb/tb_wishbone_arbiter.sv
// Randomized scoreboard bench for wishbone_arbiter: a transaction-level model predicts
// every output each cycle; a negedge monitor pops and compares.
module tb_wishbone_arbiter;

    localparam int N = 3;
    localparam int T = 4;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic [N-1:0]      m_cyc = '0, m_stb = '0, m_we = '0;
    logic [32*N-1:0]   m_adr = '0, m_dat = '0;
    logic [4*N-1:0]    m_sel = '0;
    logic [31:0]       s_dat = '0;
    logic              s_ack = 1'b0, s_err = 1'b0, s_rty = 1'b0;

    logic [31:0]       d_mdat;
    logic [N-1:0]      d_ack, d_err, d_rty, d_grant;
    logic              d_cyc, d_stb, d_we;
    logic [31:0]       d_adr, d_dat;
    logic [3:0]        d_sel;

    wishbone_arbiter #(.N_MASTERS(N), .TIMEOUT(T)) dut (
        .clk_i(clk), .rstn_i(rstn),
        .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_we_i(m_we),
        .m_adr_i(m_adr), .m_dat_i(m_dat), .m_sel_i(m_sel),
        .m_dat_o(d_mdat), .m_ack_o(d_ack), .m_err_o(d_err), .m_rty_o(d_rty),
        .s_cyc_o(d_cyc), .s_stb_o(d_stb), .s_we_o(d_we),
        .s_adr_o(d_adr), .s_dat_o(d_dat), .s_sel_o(d_sel),
        .s_dat_i(s_dat), .s_ack_i(s_ack), .s_err_i(s_err), .s_rty_i(s_rty),
        .grant_o(d_grant)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] grant, ack, err, rty;
        logic         cyc, stb, we;
        logic [31:0]  adr, dat, mdat;
        logic [3:0]   sel;
    } exp_t;

    exp_t q[$];
    int   compared = 0;
    int   mismatched = 0;

    // Reference model: who owns the bus, who owned it last, cycles a strobe has waited.
    bit busy;
    int owner, last, wcnt;

    function automatic void model_reset();
        busy  = 1'b0;
        owner = 0;
        last  = N - 1;
        wcnt  = 0;
    endfunction

    function automatic void model_edge();
        if (!rstn) begin
            model_reset();
        end else if (!busy) begin
            wcnt = 0;
            for (int i = 1; i <= N; i++) begin
                int c = (last + i) % N;
                if (m_cyc[c]) begin
                    owner = c;
                    last  = c;
                    busy  = 1'b1;
                    break;
                end
            end
        end else begin
            if (s_ack || s_err || s_rty)
                wcnt = 0;
            else if (m_stb[owner])
                wcnt = (wcnt == T - 1) ? 0 : wcnt + 1;
            if (!m_cyc[owner])
                busy = 1'b0;
        end
    endfunction

    function automatic exp_t expect_now();
        exp_t e;
        bit   to;
        e.grant = '0; e.ack = '0; e.err = '0; e.rty = '0;
        e.cyc = 1'b0; e.stb = 1'b0; e.we = 1'b0;
        e.adr = '0; e.dat = '0; e.sel = '0;
        e.mdat = s_dat;
        if (busy) begin
            e.grant = N'(1) << owner;
            e.cyc   = m_cyc[owner];
            e.stb   = m_stb[owner];
            e.we    = m_we[owner];
            e.adr   = m_adr[32*owner +: 32];
            e.dat   = m_dat[32*owner +: 32];
            e.sel   = m_sel[4*owner +: 4];
            to      = e.stb && !(s_ack || s_err || s_rty) && (wcnt == T - 1);
            if (s_ack)       e.ack = e.grant;
            if (s_err || to) e.err = e.grant;
            if (s_rty)       e.rty = e.grant;
        end
        return e;
    endfunction

    task automatic step(input logic [N-1:0] cyc, input logic ack, input logic err,
                        input logic rty, input logic rn, input bit fix);
        @(posedge clk);
        model_edge();
        #1;
        rstn  = rn;
        m_cyc = cyc;
        m_stb = cyc;
        for (int k = 0; k < N; k++) begin
            m_adr[32*k +: 32] = $urandom;
            m_dat[32*k +: 32] = $urandom;
            m_sel[4*k +: 4]   = 4'($urandom);
            m_we[k]           = 1'($urandom);
        end
        if (fix) begin
            m_adr[31:0] = 32'h0000_0010;
            m_dat[31:0] = 32'hDEAD_BEEF;
            m_sel[3:0]  = 4'hF;
            m_we[0]     = 1'b1;
        end
        s_dat = $urandom;
        s_ack = ack;
        s_err = err;
        s_rty = rty;
        if (!rn) model_reset();
        q.push_back(expect_now());
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("grant", 32'(d_grant), 32'(e.grant));
            chk("m_ack", 32'(d_ack),   32'(e.ack));
            chk("m_err", 32'(d_err),   32'(e.err));
            chk("m_rty", 32'(d_rty),   32'(e.rty));
            chk("s_cyc", 32'(d_cyc),   32'(e.cyc));
            chk("s_stb", 32'(d_stb),   32'(e.stb));
            chk("s_we",  32'(d_we),    32'(e.we));
            chk("s_adr", d_adr,        e.adr);
            chk("s_dat", d_dat,        e.dat);
            chk("s_sel", 32'(d_sel),   32'(e.sel));
            chk("m_dat", d_mdat,       e.mdat);
        end
    end

    initial begin
        logic [N-1:0] want;
        int           stall;
        int           r;
        logic         a, er, rt, rn;

        model_reset();
        repeat (3) step('0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Single write from master 0 acked in its first granted cycle.
        step(3'b001, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        step(3'b001, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        step(3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Masters 0 and 1 alternate single-beat cycles.
        for (int rnd = 0; rnd < 4; rnd++) begin
            step(3'b011, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            step(3'b011, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
            step((rnd % 2 == 0) ? 3'b010 : 3'b001, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        end
        step(3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Master 1 owns while master 0 requests; master 0 only gets the bus afterwards.
        step(3'b010, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(3'b010, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(3'b011, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        step(3'b011, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(3'b001, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(3'b001, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(3'b001, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        step(3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Silent slave: forced errors every T strobe cycles, ownership kept.
        for (int i = 0; i < 11; i++) step(3'b100, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Four-beat burst from master 0.
        step(3'b001, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step(3'b001, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        step(3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Reset in the middle of a master 1 cycle, then master 0 wins.
        step(3'b010, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(3'b010, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(3'b010, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(3'b011, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(3'b011, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        step(3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        want  = '0;
        stall = 0;
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < N; k++) begin
                if (want[k]) begin
                    if ($urandom_range(0, 3) == 0) want[k] = 1'b0;
                end else if ($urandom_range(0, 2) == 0) begin
                    want[k] = 1'b1;
                end
            end
            a = 1'b0; er = 1'b0; rt = 1'b0;
            if (stall > 0) begin
                stall--;
            end else begin
                r = int'($urandom_range(0, 99));
                if (r < 45)      a  = 1'b1;
                else if (r < 50) er = 1'b1;
                else if (r < 55) rt = 1'b1;
                else if (r < 60) stall = int'($urandom_range(3, 10));
            end
            rn = ($urandom_range(0, 299) != 0);
            step(want, a, er, rt, rn, 1'b0);
        end

        for (int w = 0; w < 5 && q.size() > 0; w++) @(negedge clk);
        #1;
        if (q.size() != 0) begin
            compared++;
            mismatched++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
